cache_2way_wt: RTL
==================

Name: cache_2way_wt

Overview:
- Parametrised 2-way set-associative, write-through, no-write-allocate cache between a CPU port and a word-addressed backing RAM.
- Successor to the direct-mapped single-config cache. Adds:
  - explicit valid/ready CPU handshake and req/ack memory handshake (no embedded RAM);
  - LRU replacement;
  - reset-cleared valid bits;
  - saturating hit/miss statistics counters.

Parameters:
- ADDR_W, 32, CPU byte-address width.
- DATA_W, 32, data word width.
- INDEX_W, 8, set index bits (2**INDEX_W sets, 2 ways each).
- CNT_W, 16, width of hit/miss counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cpu_req_valid  in  1  request present.
- cpu_req_ready  out  1  cache can accept (high only in IDLE).
- cpu_wr  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- cpu_wdata  in  DATA_W  write data.
- cpu_resp_valid  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data, valid with cpu_resp_valid.
- cpu_hit  out  1  qualifies cpu_resp_valid: 1=hit, 0=miss.
- mem_req  out  1  memory request, held until acked.
- mem_wr  out  1  memory request is a write.
- mem_addr  out  ADDR_W  memory byte address (the latched cpu_addr).
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  memory completion; mem_rdata valid same cycle for reads.
- mem_rdata  in  DATA_W  memory read data.
- hit_count  out  CNT_W  saturating count of hits.
- miss_count  out  CNT_W  saturating count of misses.

Behaviour:
- Address split:
  - index = addr[INDEX_W+1:2];
  - tag = addr[ADDR_W-1:INDEX_W+2].
- Per set: valid[2], tag[2], data[2], one LRU bit. The LRU bit names the least-recently-used way.
- Reset (async, any state):
  - state=IDLE;
  - all valid and LRU bits=0;
  - cpu_resp_valid, cpu_hit, mem_req, mem_wr=0;
  - cpu_rdata, mem_addr, mem_wdata=0;
  - counters=0.
  - mem_req drops immediately, even mid-transaction. A later mem_ack is ignored.
- State IDLE:
  - cpu_req_ready=1.
  - On the edge where cpu_req_valid&&cpu_req_ready: latch addr/wr/wdata, go to LOOKUP.
- State LOOKUP (one cycle), compare both ways:
  - hit_w = valid[w] && tag match; way 0 wins if both match.
  - Read hit: cpu_rdata<=data[hit way]; LRU<=other way; hit_count++; go to RESP with cpu_hit=1.
  - Read miss: miss_count++; mem_req<=1, mem_wr<=0; go to MEM_RD.
  - Write hit: data[hit way]<=wdata; LRU<=other way; hit_count++.
  - Write miss: miss_count++; no allocation, LRU unchanged.
  - Both write cases: mem_req<=1, mem_wr<=1, mem_wdata<=wdata; go to MEM_WR.
- State MEM_RD: hold mem_req/mem_addr stable. On mem_ack:
  - victim = first invalid way (0 before 1), else LRU way;
  - fill victim valid/tag/data from mem_rdata;
  - LRU<=other way than victim;
  - cpu_rdata<=mem_rdata; mem_req<=0; go to RESP with cpu_hit=0.
- State MEM_WR: hold outputs. On mem_ack: mem_req<=0; cpu_rdata<=wdata; go to RESP with cpu_hit=the LOOKUP result.
- State RESP: cpu_resp_valid=1 for exactly one cycle, then IDLE.
- Latency:
  - Read hit: resp_valid asserted 2 cycles after the accept edge.
  - Misses and writes: 2 cycles + mem_ack wait + 1.
- mem_ack outside MEM_RD/MEM_WR is ignored.
- Counters saturate at all-ones and never wrap.
- Only one transaction is outstanding. cpu_req_valid outside IDLE is not accepted and has no effect.

Test Plan:
- Reset, then read 0x0000_0010; memory acks after 3 cycles with 0xDEADBEEF → resp_valid, hit=0, rdata=0xDEADBEEF, miss_count=1. Repeat read → resp_valid 2 cycles after accept, hit=1, no mem_req, hit_count=1.
- Write 0x10 ← 0x12345678 after the fill → mem_req with mem_wr=1 and wdata=0x12345678; response hit=1. Read 0x10 → hit, rdata=0x12345678.
- Same-set conflict (INDEX_W=8): fill A=0x0000, B=0x0400; read A (LRU→B); fill C=0x0800 → evicts B. Read A hits; read B misses.
- Write miss to an uncached 0x20 → memory write issued, hit=0. Subsequent read of 0x20 misses (no allocate).
- Assert rst while in MEM_RD with mem_req=1 → mem_req=0 immediately. A late mem_ack is ignored. Prior cached address now misses; counters=0.
- CNT_W=2: four hits → hit_count stays 3 after the third.

Source files
------------

// File: rtl/cache_2way_wt.sv
// 2-way set-associative, write-through, no-write-allocate cache with LRU replacement,
// valid/ready CPU handshake, req/ack memory handshake and saturating hit/miss counters.
module cache_2way_wt #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned INDEX_W = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hit,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int unsigned SETS  = 2 ** INDEX_W;
  localparam int unsigned TAG_W = ADDR_W - INDEX_W - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MEM_RD,
    S_MEM_WR,
    S_RESP
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_lk_hit;
  logic [SETS-1:0]     r_valid0;
  logic [SETS-1:0]     r_valid1;
  logic [SETS-1:0]     r_lru;
  logic [TAG_W-1:0]    r_tag0  [SETS];
  logic [TAG_W-1:0]    r_tag1  [SETS];
  logic [DATA_W-1:0]   r_data0 [SETS];
  logic [DATA_W-1:0]   r_data1 [SETS];

  logic [INDEX_W-1:0]  w_index;
  logic [TAG_W-1:0]    w_tag;
  logic                w_hit0;
  logic                w_hit1;
  logic                w_hit;
  logic                w_hit_way;
  logic [DATA_W-1:0]   w_hit_data;
  logic                w_victim;
  logic                w_wr_hit;
  logic                w_fill;
  logic                w_arr_we;
  logic                w_arr_way;
  logic [DATA_W-1:0]   w_arr_data;

  assign w_index    = r_addr[INDEX_W+1:2];
  assign w_tag      = r_addr[ADDR_W-1:INDEX_W+2];
  assign w_hit0     = r_valid0[w_index] && (r_tag0[w_index] == w_tag);
  assign w_hit1     = r_valid1[w_index] && (r_tag1[w_index] == w_tag);
  assign w_hit      = w_hit0 || w_hit1;
  assign w_hit_way  = !w_hit0;
  assign w_hit_data = w_hit0 ? r_data0[w_index] : r_data1[w_index];
  // Fill the first invalid way, otherwise replace the least-recently-used one
  assign w_victim   = !r_valid0[w_index] ? 1'b0 :
                      !r_valid1[w_index] ? 1'b1 : r_lru[w_index];

  assign w_wr_hit   = (r_state == S_LOOKUP) && r_wr && w_hit;
  assign w_fill     = (r_state == S_MEM_RD) && mem_ack;
  assign w_arr_we   = w_wr_hit || w_fill;
  assign w_arr_way  = w_fill ? w_victim : w_hit_way;
  assign w_arr_data = w_fill ? mem_rdata : r_wdata;

  // Tag/data storage carries no reset; the valid bits qualify it
  always_ff @(posedge clk) begin
    if (w_arr_we) begin
      if (w_arr_way) begin
        r_tag1[w_index]  <= w_tag;
        r_data1[w_index] <= w_arr_data;
      end else begin
        r_tag0[w_index]  <= w_tag;
        r_data0[w_index] <= w_arr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_addr         <= '0;
      r_wr           <= 1'b0;
      r_wdata        <= '0;
      r_lk_hit       <= 1'b0;
      r_valid0       <= '0;
      r_valid1       <= '0;
      r_lru          <= '0;
      cpu_req_ready  <= 1'b1;
      cpu_resp_valid <= 1'b0;
      cpu_rdata      <= '0;
      cpu_hit        <= 1'b0;
      mem_req        <= 1'b0;
      mem_wr         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      hit_count      <= '0;
      miss_count     <= '0;
    end else begin
      cpu_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cpu_req_valid) begin
            r_addr        <= cpu_addr;
            r_wr          <= cpu_wr;
            r_wdata       <= cpu_wdata;
            cpu_req_ready <= 1'b0;
            r_state       <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_lk_hit <= w_hit;
          if (w_hit) begin
            r_lru[w_index] <= !w_hit_way;
            if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
          end else begin
            if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
          end
          if (r_wr) begin
            mem_req   <= 1'b1;
            mem_wr    <= 1'b1;
            mem_addr  <= r_addr;
            mem_wdata <= r_wdata;
            r_state   <= S_MEM_WR;
          end else if (w_hit) begin
            cpu_rdata <= w_hit_data;
            cpu_hit   <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            mem_req  <= 1'b1;
            mem_wr   <= 1'b0;
            mem_addr <= r_addr;
            r_state  <= S_MEM_RD;
          end
        end
        S_MEM_RD: begin
          if (mem_ack) begin
            if (w_victim) r_valid1[w_index] <= 1'b1;
            else          r_valid0[w_index] <= 1'b1;
            r_lru[w_index] <= !w_victim;
            cpu_rdata      <= mem_rdata;
            cpu_hit        <= 1'b0;
            mem_req        <= 1'b0;
            r_state        <= S_RESP;
          end
        end
        S_MEM_WR: begin
          if (mem_ack) begin
            cpu_rdata <= r_wdata;
            cpu_hit   <= r_lk_hit;
            mem_req   <= 1'b0;
            r_state   <= S_RESP;
          end
        end
        S_RESP: begin
          cpu_resp_valid <= 1'b1;
          cpu_req_ready  <= 1'b1;
          r_state        <= S_IDLE;
        end
        default: begin
          cpu_req_ready <= 1'b1;
          mem_req       <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule
